// File: rtl/bus_xfer_sequencer.sv
// Bus transfer sequencer: queues (source, destination) register-transfer requests and
// replays each one as a one-cycle bus-settle phase followed by a load phase.
//  state   | meaning
//  S_IDLE  | no transfer in flight, waiting for a queued request
//  S_DRIVE | source strobe driven, bus settling
//  S_LATCH | source held, destination load strobe asserted
module bus_xfer_sequencer #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 24,
  parameter int NDST  = 24
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_src,
  input  logic [4:0]      req_dst,
  output logic [NSRC-1:0] src_out,
  output logic [NDST-1:0] dst_in,
  output logic            xfer_done,
  output logic            busy,
  output logic            err_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [1:0]      r_state;
  logic [4:0]      r_cur_src;
  logic [4:0]      r_cur_dst;
  logic [NSRC-1:0] r_src_out;
  logic [NDST-1:0] r_dst_in;
  logic            r_done;
  logic            r_err;

  logic            w_accept;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic [9:0]      w_head;
  logic [NSRC-1:0] w_src_dec;
  logic [NDST-1:0] w_dst_dec;

  assign req_ready = (r_count != (AW+1)'(DEPTH));
  assign w_accept  = req_valid & req_ready;
  assign w_illegal = (req_src >= 5'(NSRC)) | (req_dst >= 5'(NDST));
  assign w_push    = w_accept & ~w_illegal;
  assign w_pop     = ((r_state == S_IDLE) | (r_state == S_LATCH)) & (r_count != '0);
  assign w_head    = r_mem[r_rptr];
  assign w_src_dec = NSRC'(1) << r_cur_src;
  assign w_dst_dec = NDST'(1) << r_cur_dst;

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {req_src, req_dst};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept & w_illegal) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_cur_src <= '0;
      r_cur_dst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_DRIVE;
            r_cur_src <= w_head[9:5];
            r_cur_dst <= w_head[4:0];
          end
        end
        S_DRIVE: r_state <= S_LATCH;
        S_LATCH: begin
          if (w_pop) begin
            r_state   <= S_DRIVE;
            r_cur_src <= w_head[9:5];
            r_cur_dst <= w_head[4:0];
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are a register stage behind the state so they come straight off flops.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_src_out <= '0;
      r_dst_in  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_src_out <= ((r_state == S_DRIVE) | (r_state == S_LATCH)) ? w_src_dec : '0;
      r_dst_in  <= (r_state == S_LATCH) ? w_dst_dec : '0;
      r_done    <= (r_state == S_LATCH);
    end
  end

  assign src_out     = r_src_out;
  assign dst_in      = r_dst_in;
  assign xfer_done   = r_done;
  assign err_illegal = r_err;
  assign busy        = (r_count != '0) | (r_state != S_IDLE) | r_done;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed and random checks of bus_xfer_sequencer: latency, ordering, backpressure,
// illegal codes, asynchronous clear and strobe invariants.
module tb_bus_xfer_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        xfer_done;
  logic        busy;
  logic        err_illegal;

  int n_chk;
  int n_fail;
  int cyc;
  logic [9:0] exp_q[$];

  bus_xfer_sequencer #(.DEPTH(4), .NSRC(24), .NDST(24)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .src_out(src_out), .dst_in(dst_in),
    .xfer_done(xfer_done), .busy(busy), .err_illegal(err_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: strobe invariants every cycle, and each done must match the oldest legal request.
  always @(negedge clock) begin
    if (clear) begin
      chk("src_onehot0", ($countones(src_out) <= 1), 1);
      chk("dst_onehot0", ($countones(dst_in) <= 1), 1);
      chk("dst_needs_src", ((dst_in != 0) && (src_out == 0)), 0);
      chk("done_vs_dst", xfer_done, (dst_in != 0));
      if (xfer_done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", xfer_done, 0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("done_src", src_out, 24'(1) << e[9:5]);
          chk("done_dst", dst_in, 24'(1) << e[4:0]);
        end
      end
    end
  end

  task automatic send(input logic [4:0] s, input logic [4:0] d, output int stalls);
    bit acc;
    acc = 0;
    stalls = 0;
    req_valid = 1'b1;
    req_src = s;
    req_dst = d;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clock);
      if (req_ready) acc = 1;
      else stalls++;
      @(posedge clock);
      #1;
    end
    if (!acc) chk("send_timeout", acc, 1);
    else if (s < 24 && d < 24) exp_q.push_back({s, d});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int st;
    int stalls_tot;
    int t_done[4];
    int nd;
    logic [4:0] srcs[4];
    logic [4:0] dsts[4];

    n_chk = 0; n_fail = 0; cyc = 0;
    clear = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_src", src_out, 0);
    chk("rst_dst", dst_in, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_ready", req_ready, 1);
    clear = 1'b1;
    @(posedge clock);
    #1;

    // 1: single R5->R2, exact latency
    send(5'd5, 5'd2, st);
    req_valid = 1'b0;
    chk("t1_stall", st, 0);
    chk("t1_busy_k", busy, 1);
    @(posedge clock); #1;
    chk("t1_k1_src", src_out, 0);
    @(posedge clock); #1;
    chk("t1_drive_src", src_out, 24'h000020);
    chk("t1_drive_dst", dst_in, 0);
    chk("t1_drive_done", xfer_done, 0);
    @(posedge clock); #1;
    chk("t1_latch_src", src_out, 24'h000020);
    chk("t1_latch_dst", dst_in, 24'h000004);
    chk("t1_latch_done", xfer_done, 1);
    chk("t1_latch_busy", busy, 1);
    @(posedge clock); #1;
    chk("t1_after_src", src_out, 0);
    chk("t1_after_busy", busy, 0);

    // 2: back-to-back PC->MAR, MDR->IR, R1->Y, Zlow->R7
    srcs = '{5'd20, 5'd21, 5'd1, 5'd19};
    dsts = '{5'd20, 5'd22, 5'd23, 5'd7};
    stalls_tot = 0;
    for (int i = 0; i < 4; i++) begin
      send(srcs[i], dsts[i], st);
      stalls_tot += st;
    end
    req_valid = 1'b0;
    chk("t2_stalls", stalls_tot, 0);
    nd = 0;
    for (int n = 0; n < 40 && nd < 4; n++) begin
      if (xfer_done) begin
        t_done[nd] = cyc;
        nd++;
      end
      @(posedge clock); #1;
    end
    chk("t2_done_count", nd, 4);
    for (int i = 1; i < 4; i++) chk("t2_done_gap", t_done[i] - t_done[i-1], 2);
    drain("t2_drain");

    // 3: eight requests in a stream; FIFO fills and the eighth waits exactly one cycle
    stalls_tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(5'(i + 8), 5'(15 - i), st);
      stalls_tot += st;
    end
    req_valid = 1'b0;
    chk("t3_stalls", stalls_tot, 1);
    drain("t3_drain");

    // 4: illegal codes are accepted, flagged, and never executed
    chk("t4_err_before", err_illegal, 0);
    send(5'd25, 5'd3, st);
    req_valid = 1'b0;
    chk("t4_stall", st, 0);
    chk("t4_err_set", err_illegal, 1);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("t4_no_src", src_out, 0);
      chk("t4_idle", busy, 0);
    end
    send(5'd3, 5'd30, st);
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("t4_dst_ill_busy", busy, 0);
    chk("t4_err_sticky", err_illegal, 1);

    // 5: clear during LATCH of HI->R0
    send(5'd16, 5'd0, st);
    req_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("t5_latch_src", src_out, 24'h010000);
    chk("t5_latch_dst", dst_in, 24'h000001);
    exp_q.delete();
    clear = 1'b0;
    #1;
    chk("t5_clr_src", src_out, 0);
    chk("t5_clr_dst", dst_in, 0);
    chk("t5_clr_done", xfer_done, 0);
    chk("t5_clr_err", err_illegal, 0);
    chk("t5_clr_ready", req_ready, 1);
    #1;
    clear = 1'b1;
    @(posedge clock); #1;
    chk("t5_busy_after", busy, 0);
    chk("t5_src_after", src_out, 0);

    // 6: random legal traffic with random idle gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(posedge clock); #1;
      end
      send(5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)), st);
    end
    req_valid = 1'b0;
    drain("t6_drain");
    @(posedge clock); #1;
    chk("t6_all_done", exp_q.size(), 0);
    chk("t6_err", err_illegal, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
